// File: rtl/pim_scheduler_pkg.sv
// Shared sizing constants and types for the PIM tile scheduler.
package pim_scheduler_pkg;

  localparam int MATRIX_SIZE = 4;
  localparam int CHUNK_SIZE  = 2;
  localparam int WIDTH       = 8;
  localparam int NUM_BLK     = MATRIX_SIZE / CHUNK_SIZE;
  localparam int BLK_W       = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int NUM_TILES   = NUM_BLK * NUM_BLK;

  typedef logic [BLK_W-1:0] blk_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } sched_state_t;

  function automatic logic blk_last(input blk_idx_t b);
    return b == blk_idx_t'(NUM_BLK - 1);
  endfunction

endpackage

// File: rtl/pim_scheduler_prio_enc.sv
// Lowest-index priority encoder with one-hot and binary index outputs.
module pim_prio_enc #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    // Walk downward so the lowest set bit is the one that sticks.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pim_scheduler.sv
// Dispatches row-major matrix tiles to free pim_units and drains their results
// into the aggregator one tile per cycle.
module pim_scheduler
  import pim_scheduler_pkg::*;
#(
  parameter int NUM_PIM = 4,
  localparam int UNIT_W = (NUM_PIM > 1) ? $clog2(NUM_PIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_PIM-1:0]       pim_valid,
  output blk_idx_t [NUM_PIM-1:0]   pim_row_blk,
  output blk_idx_t [NUM_PIM-1:0]   pim_col_blk,
  input  logic [NUM_PIM-1:0]       pim_result_valid,
  output logic                     agg_we,
  output logic [UNIT_W-1:0]        agg_unit,
  output blk_idx_t                 agg_row_blk,
  output blk_idx_t                 agg_col_blk
);

  localparam int CNT_W = $clog2(NUM_TILES + 1);
  localparam logic [CNT_W-1:0] TILES_C = CNT_W'(NUM_TILES);

  sched_state_t state, state_nxt;

  logic [NUM_PIM-1:0] unit_busy;
  logic [NUM_PIM-1:0] result_pending;
  blk_idx_t           tag_row [NUM_PIM];
  blk_idx_t           tag_col [NUM_PIM];
  blk_idx_t           row_blk, col_blk;
  logic [CNT_W-1:0]   issued_cnt;
  logic [CNT_W-1:0]   done_cnt;

  logic [NUM_PIM-1:0] free_req, free_oh, pend_oh;
  logic [UNIT_W-1:0]  free_idx, pend_idx;
  logic               free_any, pend_any;
  logic               dispatch, drain, last_drain;
  logic [NUM_PIM-1:0] disp_mask, drain_mask;

  assign free_req = ~unit_busy;

  pim_prio_enc #(.N(NUM_PIM)) u_free_enc (
    .req    (free_req),
    .onehot (free_oh),
    .idx    (free_idx),
    .any    (free_any)
  );

  pim_prio_enc #(.N(NUM_PIM)) u_pend_enc (
    .req    (result_pending),
    .onehot (pend_oh),
    .idx    (pend_idx),
    .any    (pend_any)
  );

  assign dispatch   = (state == ST_RUN) && (issued_cnt != TILES_C) && free_any;
  assign drain      = (state == ST_RUN) && pend_any;
  assign last_drain = drain && (done_cnt == TILES_C - 1'b1);
  assign disp_mask  = dispatch ? free_oh : '0;
  assign drain_mask = drain ? pend_oh : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (last_drain) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_FINISH);
  assign agg_we      = drain;
  assign agg_unit    = drain ? pend_idx : '0;
  assign agg_row_blk = drain ? tag_row[pend_idx] : '0;
  assign agg_col_blk = drain ? tag_col[pend_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      unit_busy      <= '0;
      result_pending <= '0;
      row_blk        <= '0;
      col_blk        <= '0;
      issued_cnt     <= '0;
      done_cnt       <= '0;
      pim_valid      <= '0;
      pim_row_blk    <= '0;
      pim_col_blk    <= '0;
      for (int u = 0; u < NUM_PIM; u++) begin
        tag_row[u] <= '0;
        tag_col[u] <= '0;
      end
    end else begin
      state     <= state_nxt;
      pim_valid <= disp_mask;
      // A unit freed by drain this cycle only becomes dispatchable next cycle.
      unit_busy      <= (unit_busy | disp_mask) & ~drain_mask;
      result_pending <= (result_pending | (pim_result_valid & unit_busy)) & ~drain_mask;

      if (state == ST_IDLE && start) begin
        row_blk    <= '0;
        col_blk    <= '0;
        issued_cnt <= '0;
        done_cnt   <= '0;
      end

      if (dispatch) begin
        pim_row_blk[free_idx] <= row_blk;
        pim_col_blk[free_idx] <= col_blk;
        tag_row[free_idx]     <= row_blk;
        tag_col[free_idx]     <= col_blk;
        issued_cnt            <= issued_cnt + 1'b1;
        if (blk_last(col_blk)) begin
          col_blk <= '0;
          row_blk <= blk_last(row_blk) ? '0 : row_blk + 1'b1;
        end else begin
          col_blk <= col_blk + 1'b1;
        end
      end

      if (drain) done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pim_scheduler.sv
// Randomized bench for pim_scheduler against a tile-level scheduling model.
module tb_pim_scheduler;
  import pim_scheduler_pkg::*;

  localparam int NP = 4;
  localparam int NB = NUM_BLK;
  localparam int NT = NB * NB;

  logic clk = 1'b0;
  logic rst, start, start2;
  logic busy, done, agg_we;
  logic [NP-1:0] pim_valid, pim_result_valid;
  blk_idx_t [NP-1:0] pim_row_blk, pim_col_blk;
  logic [1:0] agg_unit;
  blk_idx_t agg_row_blk, agg_col_blk;

  logic busy2, done2, agg_we2;
  logic [1:0] pim_valid2, rv2, pv2_prev, unread2;
  blk_idx_t [1:0] pim_row2, pim_col2;
  logic [0:0] agg_unit2;
  blk_idx_t agg_row2, agg_col2;

  always #5 clk = ~clk;

  pim_scheduler #(.NUM_PIM(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pim_valid(pim_valid), .pim_row_blk(pim_row_blk), .pim_col_blk(pim_col_blk),
    .pim_result_valid(pim_result_valid), .agg_we(agg_we), .agg_unit(agg_unit),
    .agg_row_blk(agg_row_blk), .agg_col_blk(agg_col_blk)
  );

  pim_scheduler #(.NUM_PIM(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .pim_valid(pim_valid2), .pim_row_blk(pim_row2), .pim_col_blk(pim_col2),
    .pim_result_valid(rv2), .agg_we(agg_we2), .agg_unit(agg_unit2),
    .agg_row_blk(agg_row2), .agg_col_blk(agg_col2)
  );

  int checks = 0, failures = 0;
  int cyc = 0;

  // tile-level model: tiles numbered 0..NT-1 in row-major order
  bit m_run, m_fin;
  bit m_busy[NP], m_pend[NP];
  int m_tag[NP], m_prow[NP], m_pcol[NP];
  int m_next, m_comp;
  int m_pv = -1;

  int lat[NP], ucnt[NP];
  logic [NP-1:0] rv_unit, stray, unread;
  int viol, bad, n_done, n_agg, first_cyc;
  logic [63:0] obs_vec, exp_vec, first_obs, first_exp;
  int disp_log[$], agg_cyc[$], agg_u[$];

  int tile2[2];
  int viol2, bad2, n_done2;
  int disp2[$];

  task automatic model_next();
    int du, su;
    if (rst) begin
      m_run = 0; m_fin = 0; m_next = 0; m_comp = 0; m_pv = -1;
      for (int u = 0; u < NP; u++) begin
        m_busy[u] = 0; m_pend[u] = 0; m_tag[u] = 0; m_prow[u] = 0; m_pcol[u] = 0;
      end
    end else begin
      du = -1; su = -1;
      for (int u = NP - 1; u >= 0; u--) begin
        if (m_run && m_pend[u]) du = u;
        if (m_run && m_next < NT && !m_busy[u]) su = u;
      end
      for (int u = 0; u < NP; u++) begin
        m_pend[u] = (m_pend[u] || (pim_result_valid[u] && m_busy[u])) && (u != du);
        m_busy[u] = (m_busy[u] || (u == su)) && (u != du);
      end
      m_pv = su;
      if (su >= 0) begin
        m_tag[su] = m_next; m_prow[su] = m_next / NB; m_pcol[su] = m_next % NB;
        m_next++;
      end
      if (du >= 0) m_comp++;
      if (m_fin) m_fin = 0;
      else if (m_run) begin
        if (du >= 0 && m_comp == NT) begin m_run = 0; m_fin = 1; end
      end else if (start) begin
        m_run = 1; m_next = 0; m_comp = 0;
      end
    end
  endtask

  function automatic logic [63:0] model_outputs();
    int du, t;
    logic [NP-1:0] epv;
    blk_idx_t [NP-1:0] er, ec;
    du = -1;
    for (int u = NP - 1; u >= 0; u--) if (m_run && m_pend[u]) du = u;
    epv = '0;
    if (m_pv >= 0) epv[m_pv] = 1'b1;
    for (int u = 0; u < NP; u++) begin
      er[u] = blk_idx_t'(m_prow[u]);
      ec[u] = blk_idx_t'(m_pcol[u]);
    end
    t = (du >= 0) ? m_tag[du] : 0;
    return 64'({m_run, m_fin, epv, du >= 0, 2'((du >= 0) ? du : 0),
                blk_idx_t'(t / NB), blk_idx_t'(t % NB), er, ec});
  endfunction

  task automatic step();
    bit rst_s;
    rst_s = rst;
    model_next();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_vec = model_outputs();
    obs_vec = 64'({busy, done, pim_valid, agg_we, agg_unit, agg_row_blk, agg_col_blk,
                   pim_row_blk, pim_col_blk});
    if (obs_vec !== exp_vec) begin
      bad++;
      if (bad == 1) begin first_cyc = cyc; first_obs = obs_vec; first_exp = exp_vec; end
    end
    if (done) n_done++;
    if (agg_we) begin
      n_agg++; agg_cyc.push_back(cyc); agg_u.push_back(int'(agg_unit));
      unread[agg_unit] = 1'b0;
    end
    for (int u = 0; u < NP; u++) begin
      if (pim_valid[u]) begin
        if (unread[u]) viol++;
        disp_log.push_back(u * 100 + int'(pim_row_blk[u]) * NB + int'(pim_col_blk[u]));
      end
    end
    for (int u = 0; u < NP; u++) begin
      if (rst_s) begin
        ucnt[u] = 0; rv_unit[u] = 1'b0; unread[u] = 1'b0;
      end else begin
        rv_unit[u] = (ucnt[u] == 1);
        if (rv_unit[u]) unread[u] = 1'b1;
        if (ucnt[u] > 0) ucnt[u]--;
        if (pim_valid[u]) ucnt[u] = lat[u];
      end
    end
    pim_result_valid = rv_unit | stray;

    // second instance: two units, registered single-cycle response
    if (done2) n_done2++;
    if (agg_we2) begin
      if (int'(agg_row2) * NB + int'(agg_col2) != tile2[agg_unit2]) bad2++;
      unread2[agg_unit2] = 1'b0;
    end
    for (int u = 0; u < 2; u++) begin
      if (pim_valid2[u]) begin
        if (unread2[u]) viol2++;
        tile2[u] = int'(pim_row2[u]) * NB + int'(pim_col2[u]);
        disp2.push_back(u * 100 + tile2[u]);
      end
    end
    if (rst_s) begin
      rv2 = '0; pv2_prev = '0; unread2 = '0;
    end else begin
      rv2 = pv2_prev;
      unread2 = unread2 | rv2;
      pv2_prev = pim_valid2;
    end
  endtask

  task automatic clear_stats();
    bad = 0; viol = 0; n_done = 0; n_agg = 0;
    disp_log.delete(); agg_cyc.delete(); agg_u.delete();
  endtask

  task automatic run_op(input bit rand_start, output int k);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      if (rand_start) start = ($urandom_range(0, 3) == 0);
      step();
      k++;
    end
    start = 1'b0;
    step();
  endtask

  task automatic report_trace(input string name);
    checks++;
    if (bad !== 0 || viol !== 0) begin
      failures++;
      $display("FAIL %s_trace: got %0d bad cycles, %0d early relaunches (first cyc %0d obs %h exp %h), want 0",
               name, bad, viol, first_cyc, first_obs, first_exp);
    end
  endtask

  task automatic test_reset();
    clear_stats();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({busy, done, agg_we, pim_valid, busy2, done2, pim_valid2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b agg_we=%b pim_valid=%b, want all 0",
               busy, done, agg_we, pim_valid);
    end
    step();
    report_trace("reset");
  endtask

  task automatic test_single();
    int k;
    bit ok;
    clear_stats();
    for (int u = 0; u < NP; u++) lat[u] = 1;
    run_op(1'b0, k);
    checks++;
    if (k !== 7) begin
      failures++;
      $display("FAIL single_latency: got done %0d cycles after start, want 7", k);
    end
    ok = (disp_log.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && disp_log[i] != i * 101) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_dispatch: got %0d launches (first %0d), want units 0..3 taking tiles 0..3",
               disp_log.size(), (disp_log.size() > 0) ? disp_log[0] : -1);
    end
    checks++;
    if (n_done !== 1 || n_agg !== 4) begin
      failures++;
      $display("FAIL single_counts: got done=%0d writes=%0d, want 1 and 4", n_done, n_agg);
    end
    report_trace("single");
  endtask

  task automatic test_burst_drain();
    int k;
    bit ok;
    clear_stats();
    for (int u = 0; u < NP; u++) lat[u] = NP - u;
    run_op(1'b0, k);
    ok = (agg_u.size() == 4);
    for (int i = 0; i < 4; i++) begin
      if (ok && (agg_u[i] != i || agg_cyc[i] != agg_cyc[0] + i)) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL burst_drain: got %0d writes (first unit %0d), want units 0,1,2,3 on consecutive cycles",
               agg_u.size(), (agg_u.size() > 0) ? agg_u[0] : -1);
    end
    report_trace("burst");
  endtask

  task automatic test_restart_ignored();
    int k;
    clear_stats();
    for (int u = 0; u < NP; u++) lat[u] = 2;
    start = 1'b1;
    step();
    step(); step();
    start = 1'b0;
    k = 0;
    while (!done && k < 300) begin step(); k++; end
    step();
    checks++;
    if (n_done !== 1 || n_agg !== 4) begin
      failures++;
      $display("FAIL restart_counts: got done=%0d writes=%0d, want 1 and 4", n_done, n_agg);
    end
    report_trace("restart");
  endtask

  task automatic test_stray();
    int k;
    clear_stats();
    stray = 4'b1010;
    step(); step();
    stray = 4'b0000;
    step();
    checks++;
    if (n_agg !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_ignored: got writes=%0d busy=%b, want 0 and 0", n_agg, busy);
    end
    for (int u = 0; u < NP; u++) lat[u] = 1;
    run_op(1'b0, k);
    checks++;
    if (n_done !== 1 || n_agg !== 4) begin
      failures++;
      $display("FAIL stray_run: got done=%0d writes=%0d, want 1 and 4", n_done, n_agg);
    end
    report_trace("stray");
  endtask

  task automatic test_reset_mid_run();
    int k;
    clear_stats();
    for (int u = 0; u < NP; u++) lat[u] = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (disp_log.size() < 2 && k < 20) begin step(); k++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, agg_we, pim_valid, agg_unit, agg_row_blk, agg_col_blk, pim_row_blk, pim_col_blk} !== '0
        || disp_log.size() < 2) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%b agg_we=%b pim_valid=%b launches=%0d, want zeros after 2 launches",
               busy, agg_we, pim_valid, disp_log.size());
    end
    n_done = 0; n_agg = 0;
    run_op(1'b0, k);
    checks++;
    if (n_done !== 1 || n_agg !== 4) begin
      failures++;
      $display("FAIL midrst_rerun: got done=%0d writes=%0d, want 1 and 4", n_done, n_agg);
    end
    report_trace("midrst");
  endtask

  task automatic test_two_units();
    int k;
    bit ok;
    int want[4] = '{0, 101, 2, 103};
    viol2 = 0; bad2 = 0; n_done2 = 0; disp2.delete();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 100) begin step(); k++; end
    step();
    ok = (disp2.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && disp2[i] != want[i]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reuse_dispatch: got %0d launches (third %0d), want u0:(0,0) u1:(0,1) u0:(1,0) u1:(1,1)",
               disp2.size(), (disp2.size() > 2) ? disp2[2] : -1);
    end
    checks++;
    if (n_done2 !== 1 || viol2 !== 0 || bad2 !== 0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reuse_protocol: got done=%0d relaunch=%0d badtag=%0d busy=%b, want 1 0 0 0",
               n_done2, viol2, bad2, busy2);
    end
  endtask

  task automatic test_random();
    int k;
    bit ok;
    for (int r = 0; r < 8; r++) begin
      clear_stats();
      for (int u = 0; u < NP; u++) lat[u] = $urandom_range(1, 6);
      stray = NP'($urandom_range(0, 15));
      step();
      stray = '0;
      run_op(1'b1, k);
      ok = (disp_log.size() == NT);
      for (int i = 0; i < NT; i++) if (ok && disp_log[i] % 100 != i) ok = 0;
      checks++;
      if (!ok || n_done !== 1 || n_agg !== NT) begin
        failures++;
        $display("FAIL random_run%0d: got launches=%0d order_ok=%0d done=%0d writes=%0d, want %0d 1 1 %0d",
                 r, disp_log.size(), ok, n_done, n_agg, NT, NT);
      end
      report_trace("random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    stray = '0; rv_unit = '0; unread = '0; pim_result_valid = '0;
    rv2 = '0; pv2_prev = '0; unread2 = '0;
    for (int u = 0; u < NP; u++) begin lat[u] = 1; ucnt[u] = 0; end
    tile2[0] = 0; tile2[1] = 0;
    test_reset();
    test_single();
    test_burst_drain();
    test_restart_ignored();
    test_stray();
    test_reset_mid_run();
    test_two_units();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pim_scheduler.md
PIM_SCHEDULER -- requirements
Module: pim_scheduler

Interface
REQ-001 Parameter NUM_PIM, default 4, number of pim_unit instances scheduled (power of two, 2..16).
REQ-002 Package constants MATRIX_SIZE, CHUNK_SIZE and WIDTH are used; NUM_BLK = MATRIX_SIZE/CHUNK_SIZE, BLK_W = max(1, $clog2(NUM_BLK)), UNIT_W = max(1, $clog2(NUM_PIM)).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to compute one full MATRIX_SIZE x MATRIX_SIZE product.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse when all NUM_BLK^2 tiles are written to the aggregator.
REQ-008 pim_valid  output  NUM_PIM  per-unit launch pulse; drives each pim_unit valid.
REQ-009 pim_row_blk  output  NUM_PIM x BLK_W  row-block index selecting the matrixA chunk for each unit.
REQ-010 pim_col_blk  output  NUM_PIM x BLK_W  column-block index selecting the matrixB chunk for each unit.
REQ-011 pim_result_valid  input  NUM_PIM  per-unit result_valid from pim_unit.
REQ-012 agg_we  output  1  aggregator write strobe for one CHUNK_SIZE^2 tile.
REQ-013 agg_unit  output  UNIT_W  unit whose result bus the aggregator samples while agg_we is high.
REQ-014 agg_row_blk / agg_col_blk  output  BLK_W each  tile coordinates of the write.

Function
REQ-015 FSM states: IDLE, RUN, FINISH; RUN covers dispatch and drain concurrently.
REQ-016 IDLE: start high -> RUN; tile counter reset to (0,0), completed-tile count reset to 0; start ignored in RUN and FINISH.
REQ-017 Tiles are issued row-major: col_blk increments first, wraps NUM_BLK-1 -> 0 while row_blk increments.
REQ-018 At most one tile is dispatched per cycle, to the lowest-index unit whose unit_busy bit is clear; none is dispatched once all NUM_BLK^2 tiles are issued.
REQ-019 Dispatch: pim_valid[u] pulses one cycle; pim_row_blk[u]/pim_col_blk[u] are registered with the tile and held stable until that unit's next dispatch; unit_busy[u] and a per-unit tile tag are set.
REQ-020 pim_result_valid[u] with unit_busy[u] set -> result_pending[u] is set the next cycle; pim_result_valid on a non-busy unit is ignored.
REQ-021 Drain: each cycle, if any result_pending bit is set, the lowest index u is selected; agg_we=1, agg_unit=u, agg_row_blk/agg_col_blk=the tag of u; then result_pending[u] and unit_busy[u] clear and the completed count increments.
REQ-022 The unit is not redispatched until its drain, so the pim_unit result register stays stable while unread.
REQ-023 Dispatch and drain may occur in the same cycle on different units; a unit freed by drain in cycle t is eligible for dispatch in cycle t+1, not t.
REQ-024 When the completed count reaches NUM_BLK^2 -> FINISH; FINISH asserts done for one cycle and returns to IDLE; busy is low in IDLE and in FINISH.
REQ-025 Minimum latency from start to done: NUM_BLK^2 + 3 cycles with ideal unit latency 1 and NUM_PIM >= 2.
REQ-026 Counters have enough width for NUM_BLK^2 inclusive; block indices never exceed NUM_BLK-1.

Reset
REQ-027 rst clears the FSM to IDLE and clears unit_busy, result_pending, the counters, pim_valid, agg_we, done and busy to 0; block-index and tag outputs reset to 0.
REQ-028 rst during RUN abandons the operation with no done pulse; a start in the first cycle after rst deasserts is accepted.

Structure
REQ-029 A package typedef holds the block index (logic [BLK_W-1:0]); NUM_BLK and BLK_W are package constants beside MATRIX_SIZE and CHUNK_SIZE.
REQ-030 One sub-module, pim_prio_enc (lowest-index priority encoder, one-hot and index outputs), is instantiated twice: free-unit selection and pending-result selection.

Verification
REQ-031 MATRIX_SIZE=4, CHUNK_SIZE=2, NUM_PIM=4, units respond 1 cycle after valid; start -> tiles (0,0),(0,1),(1,0),(1,1) dispatch to units 0..3 on consecutive cycles; 4 agg_we with matching coordinates; done at cycle 7 after start.
REQ-032 NUM_PIM=2, NUM_BLK=2 -> units are reused; unit 0 receives (0,0) then (1,0); no pim_valid reaches a unit with result_pending set.
REQ-033 Units 0..3 assert result_valid in the same cycle -> agg_we is high for 4 consecutive cycles with agg_unit 0,1,2,3.
REQ-034 start pulsed again mid-RUN -> no effect; exactly one done; completed count is 4.
REQ-035 rst asserted after 2 dispatches -> the next cycle shows all outputs 0 and IDLE; a later start completes normally with no stale agg_we.
REQ-036 A stray pim_result_valid on an idle unit -> no agg_we and no count change.
